// File: rtl/mem_access_stage.sv
// Data-memory access stage: drives the word-wide req/ack memory port,
// forms byte lanes, extracts loads. Optional define: MEM_ALIGN_CHECK_EN.
module mem_access_stage #(
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ExValid,
    input  logic [31:0] ALUResult,
    input  logic [31:0] StoreData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        LoadSigned,
    output logic        Stall,
    output logic        WbValid,
    output logic [31:0] WbData,
    output logic        BusErr,
    output logic        AlignErr,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic        MemAck,
    input  logic [31:0] MemRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] TO_LAST = ACK_TIMEOUT - 1;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [31:0] cnt_q, cnt_d;
    logic [3:0]  be_q, be_d;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        we_q, we_d;
    logic        sign_q, sign_d;
    logic        bus_err_q, bus_err_d;
    logic        align_err_q, align_err_d;

    logic        is_mem;
    logic        is_store;
    logic        misalign;
    logic        timeout;
    logic [3:0]  lane_be;
    logic [1:0]  lane_off;
    logic [31:0] lane_wdata;
    logic [31:0] shifted;
    logic [31:0] load_val;

    // A read+write collision is handled as a load.
    assign is_mem   = MemRead | MemWrite;
    assign is_store = MemWrite & ~MemRead;
    assign timeout  = (ACK_TIMEOUT != 0) && (cnt_q == TO_LAST);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = (MemSize == 2'b01 && ALUResult[0]) ||
                      (MemSize[1] && ALUResult[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Byte lanes, replicated store data and load shift for the incoming op.
    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = StoreData;
        lane_off   = 2'b00;
        unique case (MemSize)
            2'b00: begin
                lane_be    = 4'b0001 << ALUResult[1:0];
                lane_wdata = {4{StoreData[7:0]}};
                lane_off   = ALUResult[1:0];
            end
            2'b01: begin
                lane_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{StoreData[15:0]}};
                lane_off   = {ALUResult[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Extract and extend the addressed field of the returned word.
    always_comb begin
        shifted  = MemRData >> {off_q, 3'b000};
        load_val = MemRData;
        unique case (size_q)
            2'b00: load_val = sign_q ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'b0, shifted[7:0]};
            2'b01: load_val = sign_q ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'b0, shifted[15:0]};
            default: ;
        endcase
    end

    // Next-state and datapath updates; an ack beats a same-edge timeout.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wb_data_d   = wb_data_q;
        cnt_d       = cnt_q;
        be_d        = be_q;
        size_d      = size_q;
        off_d       = off_q;
        we_d        = we_q;
        sign_d      = sign_q;
        bus_err_d   = bus_err_q;
        align_err_d = align_err_q;
        unique case (state_q)
            REQ: begin
                cnt_d = cnt_q + 32'd1;
                if (MemAck) begin
                    state_d   = RESP;
                    wb_data_d = we_q ? 32'd0 : load_val;
                    bus_err_d = 1'b0;
                end else if (timeout) begin
                    state_d   = RESP;
                    wb_data_d = 32'd0;
                    bus_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (ExValid) begin
                    bus_err_d   = 1'b0;
                    align_err_d = 1'b0;
                    if (!is_mem) begin
                        state_d   = RESP;
                        wb_data_d = ALUResult;
                    end else if (misalign) begin
                        state_d     = RESP;
                        wb_data_d   = 32'd0;
                        align_err_d = 1'b1;
                    end else begin
                        state_d = REQ;
                        addr_d  = {ALUResult[31:2], 2'b00};
                        be_d    = lane_be;
                        wdata_d = lane_wdata;
                        we_d    = is_store;
                        size_d  = MemSize;
                        sign_d  = LoadSigned;
                        off_d   = lane_off;
                        cnt_d   = 32'd0;
                    end
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wb_data_q   <= '0;
            cnt_q       <= '0;
            be_q        <= '0;
            size_q      <= '0;
            off_q       <= '0;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            bus_err_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wb_data_q   <= wb_data_d;
            cnt_q       <= cnt_d;
            be_q        <= be_d;
            size_q      <= size_d;
            off_q       <= off_d;
            we_q        <= we_d;
            sign_q      <= sign_d;
            bus_err_q   <= bus_err_d;
            align_err_q <= align_err_d;
        end
    end

    assign Stall     = (state_q == REQ);
    assign MemReq    = (state_q == REQ);
    assign WbValid   = (state_q == RESP);
    assign WbData    = wb_data_q;
    assign BusErr    = bus_err_q;
    assign AlignErr  = align_err_q;
    assign MemWe     = we_q;
    assign MemAddr   = addr_q;
    assign MemByteEn = be_q;
    assign MemWData  = wdata_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage against an arithmetic model.
// Honors MEM_ALIGN_CHECK_EN when defined for the build.
module tb_mem_access_stage;

    localparam int unsigned TO = 4;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        ExValid = 1'b0;
    logic [31:0] ALUResult = '0;
    logic [31:0] StoreData = '0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [1:0]  MemSize = '0;
    logic        LoadSigned = 1'b0;
    logic        Stall, WbValid, BusErr, AlignErr, MemReq, MemWe;
    logic [31:0] WbData, MemAddr, MemWData;
    logic [3:0]  MemByteEn;
    logic        MemAck = 1'b0;
    logic [31:0] MemRData = '0;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_wb = '0;

    mem_access_stage #(.ACK_TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset), .ExValid(ExValid),
        .ALUResult(ALUResult), .StoreData(StoreData),
        .MemRead(MemRead), .MemWrite(MemWrite),
        .MemSize(MemSize), .LoadSigned(LoadSigned),
        .Stall(Stall), .WbValid(WbValid), .WbData(WbData),
        .BusErr(BusErr), .AlignErr(AlignErr),
        .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr),
        .MemByteEn(MemByteEn), .MemWData(MemWData),
        .MemAck(MemAck), .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        return 4;
    endfunction

    function automatic int lane_off(input logic [1:0] sz, input logic [31:0] a);
        int n = nbytes(sz);
        if (n == 1) return int'(a % 4);
        if (n == 2) return int'((a % 4) / 2) * 2;
        return 0;
    endfunction

    function automatic bit model_misalign(input logic [1:0] sz, input logic [31:0] a);
        bit m = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        m = (a % nbytes(sz)) != 0;
`endif
        return m;
    endfunction

    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [31:0] a);
        int v = ((1 << nbytes(sz)) - 1) << lane_off(sz, a);
        logic [31:0] r = v;
        return r[3:0];
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] sd);
        int n = nbytes(sz);
        longint unsigned span = 64'd1 << (8 * n);
        longint unsigned s = sd;
        longint unsigned r;
        if (n == 1) r = (s % span) * 64'h0101_0101;
        else if (n == 2) r = (s % span) * 64'h0001_0001;
        else r = s;
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input bit sg,
                                             input logic [31:0] a, input logic [31:0] rd);
        int n = nbytes(sz);
        longint unsigned span = 64'd1 << (8 * n);
        longint unsigned w = rd;
        longint unsigned f = (w >> (8 * lane_off(sz, a))) % span;
        if (sg && n < 4 && f >= span / 2)
            f = f + (64'h1_0000_0000 - span);
        return f[31:0];
    endfunction

    // Starts at a negedge, ends at the negedge of the write-back cycle.
    task automatic do_op(input bit rd, input bit wr, input logic [1:0] sz,
                         input bit sg, input logic [31:0] a, input logic [31:0] sd,
                         input int waits, input logic [31:0] rdat, output int nreq);
        bit is_mem = rd | wr;
        bit st = wr && !rd;
        bit mis = is_mem && model_misalign(sz, a);
        bit acked = 1'b0;
        logic [31:0] exp_wb;
        nreq = 0;
        ExValid = 1'b1;
        MemRead = rd;
        MemWrite = wr;
        MemSize = sz;
        LoadSigned = sg;
        ALUResult = a;
        StoreData = sd;
        @(posedge Clk);
        #1;
        ExValid = 1'b0;
        MemRead = 1'b0;
        MemWrite = 1'b0;
        ALUResult = $urandom;
        StoreData = $urandom;
        if (!is_mem) begin
            exp_wb = a;
        end else if (mis) begin
            exp_wb = 32'd0;
        end else begin
            for (int i = 0; i < int'(TO); i++) begin
                @(negedge Clk);
                nreq++;
                check("req", MemReq, 1);
                check("stall", Stall, 1);
                check("addr", MemAddr, {a[31:2], 2'b00});
                check("we", MemWe, st);
                check("be", MemByteEn, exp_be(sz, a));
                if (st) check("wdata", MemWData, exp_wdata(sz, sd));
                if (i == waits) begin
                    MemAck = 1'b1;
                    MemRData = rdat;
                end
                @(posedge Clk);
                #1;
                MemAck = 1'b0;
                MemRData = $urandom;
                if (i == waits) begin
                    acked = 1'b1;
                    break;
                end
            end
            exp_wb = (acked && !st) ? exp_load(sz, sg, a, rdat) : 32'd0;
        end
        @(negedge Clk);
        check("wbvalid", WbValid, 1);
        check("wbdata", WbData, exp_wb);
        check("buserr", BusErr, is_mem && !mis && !acked);
        check("alignerr", AlignErr, mis);
        check("req_done", MemReq, 0);
        check("stall_done", Stall, 0);
        last_wb = exp_wb;
    endtask

    task automatic idle_cycle();
        @(negedge Clk);
        check("pulse", WbValid, 0);
        check("hold", WbData, last_wb);
    endtask

    initial begin
        int n;
        logic [31:0] v;
        #1;
        check("rst_req", MemReq, 0);
        check("rst_stall", Stall, 0);
        check("rst_wbv", WbValid, 0);
        check("rst_wbd", WbData, 0);
        check("rst_addr", MemAddr, 0);
        check("rst_be", MemByteEn, 0);
        check("rst_wd", MemWData, 0);
        check("rst_we", MemWe, 0);
        check("rst_bus", BusErr, 0);
        check("rst_aln", AlignErr, 0);
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;

        do_op(0, 0, 2'd2, 0, 32'h0000_002A, 32'h0, 0, 32'h0, n);
        check("alu_nreq", n, 0);
        idle_cycle();

        do_op(1, 0, 2'd0, 1, 32'h0000_0103, 32'h0, 3, 32'h80FF_0000, n);
        check("lb_stall", n, 4);
        idle_cycle();

        do_op(0, 1, 2'd1, 0, 32'h0000_0202, 32'h1234_ABCD, 1, 32'h0, n);
        check("sh_nreq", n, 2);

        do_op(1, 0, 2'd2, 0, 32'h0000_0200, 32'h0, 100, 32'h0, n);
        check("to_nreq", n, TO);
        idle_cycle();

        do_op(1, 0, 2'd2, 0, 32'h0000_0106, 32'h0, 0, 32'hCAFE_F00D, n);
`ifdef MEM_ALIGN_CHECK_EN
        check("lw_mis_nreq", n, 0);
`else
        check("lw_nreq", n, 1);
`endif
        idle_cycle();

        v = $urandom;
        ExValid = 1'b1;
        ALUResult = v;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            check("b2b_v", WbValid, 1);
            check("b2b_d", WbData, v);
            if (i < 4) begin
                v = $urandom;
                ALUResult = v;
            end else begin
                ExValid = 1'b0;
            end
        end
        last_wb = v;
        idle_cycle();

        ExValid = 1'b1;
        MemRead = 1'b1;
        MemSize = 2'd2;
        ALUResult = 32'h0000_0400;
        @(posedge Clk);
        #1;
        ExValid = 1'b0;
        MemRead = 1'b0;
        @(negedge Clk);
        check("mid_req", MemReq, 1);
        #2;
        Reset = 1'b1;
        #1;
        check("rst_async_req", MemReq, 0);
        check("rst_async_stall", Stall, 0);
        @(negedge Clk);
        Reset = 1'b0;
        MemAck = 1'b1;
        MemRData = 32'hDEAD_BEEF;
        @(posedge Clk);
        #1;
        MemAck = 1'b0;
        @(negedge Clk);
        check("late_ack_wbv", WbValid, 0);
        check("late_ack_req", MemReq, 0);
        do_op(0, 0, 2'd0, 0, 32'h0BAD_F00D, 32'h0, 0, 32'h0, n);

        for (int k = 0; k < 80; k++) begin
            int t = $urandom_range(0, 2);
            bit rd = (t == 1);
            bit wr = (t == 2) || (t == 1 && $urandom_range(0, 7) == 0);
            logic [1:0] sz = 2'($urandom_range(0, 3));
            int w = $urandom_range(0, 5);
            int ex = (w < int'(TO)) ? w + 1 : int'(TO);
            logic [31:0] a = $urandom;
            if (rd | wr) begin
                if (model_misalign(sz, a)) ex = 0;
            end else begin
                ex = 0;
            end
            do_op(rd, wr, sz, 1'($urandom), a, $urandom, w, $urandom, n);
            check("rand_nreq", n, ex);
            if ($urandom_range(0, 2) == 0) idle_cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule
